// File: rtl/kb_event_gen.sv
// rtl/kb_event_gen.sv - keyboard event word assembler with typematic auto-repeat
module kb_event_gen #(
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 1250000,
    parameter int BYTE_TIMEOUT = 25000,
    parameter int CNT_W        = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_sync,
    input  logic        repeat_en,
    output logic [15:0] kb_wrdata,
    output logic        kb_wr_en,
    output logic        drop
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_DLY = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] CNT_RATE = CNT_W'(REPEAT_RATE);
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(BYTE_TIMEOUT);
    localparam logic [15:0]      REP_FLAG = 16'h4000;

    typedef enum logic {
        ST_LOW,
        ST_HIGH
    } asm_state_t;

    asm_state_t       state;
    asm_state_t       state_nxt;
    logic [7:0]       low_byte;
    logic [CNT_W-1:0] tmo_cnt;
    logic             host_req;
    logic             drop_req;
    logic             take_low;
    logic [15:0]      host_word;

    logic             held;
    logic [15:0]      held_word;
    logic [CNT_W-1:0] rep_cnt;
    logic             rep_pend;
    logic             rep_expire;
    logic             is_press;
    logic             is_rel_held;

    // Assembler next state: sync beats data, data beats timeout.
    always_comb begin
        state_nxt = state;
        host_req  = 1'b0;
        drop_req  = 1'b0;
        take_low  = 1'b0;
        host_word = {in_data, low_byte} & ~REP_FLAG;
        case (state)
            ST_LOW: begin
                if (in_valid) begin
                    take_low  = 1'b1;
                    state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (in_sync) begin
                    drop_req  = 1'b1;
                    take_low  = in_valid;
                    state_nxt = in_valid ? ST_HIGH : ST_LOW;
                end else if (in_valid) begin
                    host_req  = 1'b1;
                    state_nxt = ST_LOW;
                end else if (tmo_cnt == CNT_ONE) begin
                    drop_req  = 1'b1;
                    state_nxt = ST_LOW;
                end
            end
            default: state_nxt = ST_LOW;
        endcase
    end

    // Assembler state, latched low byte and inter-byte timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_LOW;
            low_byte <= 8'h00;
            tmo_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (take_low) begin
                low_byte <= in_data;
                tmo_cnt  <= CNT_TMO;
            end else if (state == ST_HIGH && state_nxt == ST_HIGH) begin
                tmo_cnt <= tmo_cnt - CNT_ONE;
            end
        end
    end

    // Repeat tracker decode; a pending repeat suppresses a second expiry.
    always_comb begin
        rep_expire  = held && repeat_en && !rep_pend && (rep_cnt == CNT_ONE);
        is_press    = host_req && !host_word[15] && (host_word[7:0] != 8'h00);
        is_rel_held = host_req && host_word[15] && held
                      && (host_word[7:0] == held_word[7:0]);
    end

    // Registered emission (host word wins) and held-key/repeat counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            kb_wrdata <= 16'h0000;
            kb_wr_en  <= 1'b0;
            drop      <= 1'b0;
            held      <= 1'b0;
            held_word <= 16'h0000;
            rep_cnt   <= '0;
            rep_pend  <= 1'b0;
        end else begin
            kb_wr_en <= 1'b0;
            drop     <= drop_req;
            if (host_req) begin
                kb_wr_en  <= 1'b1;
                kb_wrdata <= host_word;
            end else if ((rep_expire || rep_pend) && held && repeat_en) begin
                kb_wr_en  <= 1'b1;
                kb_wrdata <= held_word | REP_FLAG;
            end

            if (!repeat_en) begin
                held     <= 1'b0;
                rep_pend <= 1'b0;
                rep_cnt  <= '0;
            end else if (is_press) begin
                held      <= 1'b1;
                held_word <= host_word;
                rep_cnt   <= CNT_DLY;
                rep_pend  <= 1'b0;
            end else if (is_rel_held) begin
                held     <= 1'b0;
                rep_pend <= 1'b0;
                rep_cnt  <= '0;
            end else if (held) begin
                if (host_req && rep_expire) begin
                    rep_pend <= 1'b1;
                end else if (rep_pend || rep_expire) begin
                    rep_pend <= 1'b0;
                    rep_cnt  <= CNT_RATE;
                end else begin
                    rep_cnt <= rep_cnt - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: doc/kb_event_gen.md
Name: kb_event_gen

Overview:
- Producer side of the keyboard event FIFO.
- Accepts the keyboard byte stream from the host-link command handler and assembles little-endian 16-bit key event words.
- Pushes each word into the keyboard FIFO with a single-cycle write strobe.
- Adds optional typematic auto-repeat for the most recently pressed key, so repeat timing is generated in hardware rather than by the host.

Parameters:
- REPEAT_DELAY, 12500000: cycles from press-event emission to first repeat event (500 ms at 25 MHz).
- REPEAT_RATE, 1250000: cycles between successive repeat events (50 ms at 25 MHz).
- BYTE_TIMEOUT, 25000: maximum cycles allowed between low and high byte of one word (1 ms at 25 MHz).
- CNT_W, 24: width of the internal repeat and timeout counters. Must hold the largest of the three parameters above.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- in_data  in  8  byte from host link.
- in_valid  in  1  in_data valid this cycle (single-cycle strobe).
- in_sync  in  1  frame start; forces byte assembler back to expecting a low byte.
- repeat_en  in  1  auto-repeat enable (from control register).
- kb_wrdata  out  16  event word to FIFO.
- kb_wr_en  out  1  FIFO write strobe.
- drop  out  1  one-cycle pulse when a partial word is discarded.

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values:
  - kb_wrdata = 0x0000, kb_wr_en = 0, drop = 0.
  - Assembler in LOW state; tracker empty; all counters 0.
- Reset mid-operation: any partial byte and any held key are discarded, with no emission and no drop pulse.
- Event word format:
  - [15] release flag (1 = key up).
  - [14] repeat flag.
  - [13:8] modifiers.
  - [7:0] key code.
  - Bit 14 of host-supplied words is forced to 0. Only this block sets it.
- Assembler states:
  - LOW: on in_valid, latch in_data as bits [7:0] and go to HIGH; load timeout counter with BYTE_TIMEOUT.
  - HIGH, in_valid: form word {in_data, low}, request emission, go to LOW.
  - HIGH, no in_valid: decrement timeout counter. When it would reach 0, discard the low byte, pulse drop for 1 cycle, go to LOW.
  - A byte arriving on the exact expiry cycle is accepted (in_valid has priority over timeout).
- in_sync:
  - Has priority over in_valid in the same cycle: the assembler goes to LOW and that byte is treated as a low byte.
  - In HIGH, this abandons the partial word with a drop pulse.
- Emission:
  - Registered. kb_wr_en is high exactly 1 cycle after the high byte's in_valid cycle, with kb_wrdata valid in the same cycle.
  - At most one write per cycle.
  - No backpressure: the FIFO silently drops when full, and this block does not track occupancy.
- Repeat tracker (fields: held flag, held word):
  - Press word (bit15 = 0, key != 0x00) with repeat_en = 1: held = word; counter loads REPEAT_DELAY on emission.
  - Release word whose [7:0] equals the held key: cancels held; counter stops.
  - Release of any other key: emitted; tracker unchanged.
  - Press of a different key: replaces held and reloads REPEAT_DELAY.
  - Key 0x00 presses never become held.
- Repeat emission:
  - While held, the counter decrements each cycle.
  - On the cycle it expires, emit held word with bit14 = 1 and reload REPEAT_RATE.
  - Result: first repeat exactly REPEAT_DELAY cycles after the press write, then every REPEAT_RATE cycles.
- Collision (host word emission and repeat expiry in the same cycle): the host word wins.
  - Release of the held key: repeat cancelled.
  - Press of another key: tracker reloads as above.
  - Otherwise: repeat emitted the next cycle, and the following interval is measured from that actual emission.
- repeat_en deasserted: held cleared the next cycle with no further repeats. Reasserting does not resurrect the old key; a new press is needed.
- Counter arithmetic: unsigned CNT_W bits, no wrap. Parameters of 0 or 1 are illegal and are not supported.

Test Plan:
- Reset then bytes 0x1C, 0x02 on consecutive cycles -> one kb_wr_en pulse 1 cycle after second byte, kb_wrdata = 0x021C; no drop.
- Low byte 0x1C, then idle BYTE_TIMEOUT cycles -> drop pulse once, no write; next bytes 0x20, 0x80 -> kb_wrdata = 0x8020.
- Byte 0x1C, then in_sync coincident with byte 0x55 -> drop pulse; 0x55 taken as low byte; next 0x00 -> write 0x0055.
- repeat_en = 1 (REPEAT_DELAY = 20, REPEAT_RATE = 5 in bench), press 0x0041 -> writes 0x0041 at t, 0x4041 at t+20, t+25, t+30; release 0x8041 -> release write, then no further repeats.
- Held 0x0041; release 0x8042 timed to land on repeat expiry -> 0x8042 written that cycle, 0x4041 next cycle, next repeat REPEAT_RATE after that.
- Held key, repeat_en dropped mid-delay -> no repeat writes; reassert repeat_en -> still none until a new press.
